// File: rtl/mau_sched_pkg.sv
// Shared definitions for the memory-access-unit scheduler: FSM encoding,
// parameter defaults and the per-requester field width.
package mau_sched_pkg;

    localparam int         NREQ_DEFAULT    = 4;
    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd200;
    localparam int         FIELD_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COMPLETE = 2'd3
    } state_t;

    // Round-robin pointer moves just past the requester that was served.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/mau_sched_if.sv
// Requester and MAU command bus of the scheduler; slave is the scheduler
// side, master is the environment (requesters plus MAU).
interface mau_sched_if
    import mau_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
);

    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_rw;
    logic [NREQ-1:0]         req_stride_en;
    logic [NREQ-1:0]         req_mask_en;
    logic [FIELD_W*NREQ-1:0] req_rx;
    logic [FIELD_W*NREQ-1:0] req_ry;
    logic                    halt_in;
    logic                    mau_done;

    logic                    mau_start;
    logic                    mau_rw;
    logic                    mau_stride_en;
    logic                    mau_mask_en;
    logic                    mau_halt;
    logic [FIELD_W-1:0]      mau_rx;
    logic [FIELD_W-1:0]      mau_ry;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         cmpl;
    logic                    busy;
    logic                    err;

    modport slave (
        input  req, req_rw, req_stride_en, req_mask_en, req_rx, req_ry,
        input  halt_in, mau_done,
        output mau_start, mau_rw, mau_stride_en, mau_mask_en, mau_halt,
        output mau_rx, mau_ry, gnt, cmpl, busy, err
    );

    modport master (
        output req, req_rw, req_stride_en, req_mask_en, req_rx, req_ry,
        output halt_in, mau_done,
        input  mau_start, mau_rw, mau_stride_en, mau_mask_en, mau_halt,
        input  mau_rx, mau_ry, gnt, cmpl, busy, err
    );

endinterface

// File: rtl/mau_sched_rr_arbiter4.sv
// Combinational round-robin picker for four requesters: the first set
// request at or above ptr (wrapping) wins.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       valid
);

    // Walk from farthest to nearest so the nearest candidate overrides.
    always_comb begin
        gnt   = 4'b0000;
        idx   = 2'd0;
        valid = |req;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                idx = ptr + 2'(k);
                gnt = 4'b0001 << (ptr + 2'(k));
            end
        end
    end

endmodule

// File: rtl/mau_sched.sv
// Scheduler granting one of four requesters access to the memory access
// unit, issuing a single start and tracking completion or timeout.
module mau_sched
    import mau_sched_pkg::*;
#(
    parameter int         NREQ    = NREQ_DEFAULT,
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    mau_sched_if.slave bus
);

    state_t             state;
    logic [1:0]         rr_ptr;
    logic [1:0]         gnt_idx;
    logic [7:0]         wait_cnt;
    logic [NREQ-1:0]    gnt_r;
    logic [NREQ-1:0]    cmpl_r;
    logic               err_r;
    logic               start_r;
    logic               rw_r;
    logic               stride_r;
    logic               mask_r;
    logic [FIELD_W-1:0] rx_r;
    logic [FIELD_W-1:0] ry_r;

    logic [3:0]         pick_gnt;
    logic [1:0]         pick_idx;
    logic               pick_valid;

    rr_arbiter4 u_arb (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // mau_start is registered out of ISSUE, so it appears the cycle after
    // gnt; cmpl is registered out of WAIT, so it follows mau_done by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= 2'd0;
            gnt_idx  <= 2'd0;
            wait_cnt <= 8'd0;
            gnt_r    <= '0;
            cmpl_r   <= '0;
            err_r    <= 1'b0;
            start_r  <= 1'b0;
            rw_r     <= 1'b0;
            stride_r <= 1'b0;
            mask_r   <= 1'b0;
            rx_r     <= '0;
            ry_r     <= '0;
        end else begin
            start_r <= 1'b0;
            cmpl_r  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_r    <= pick_gnt;
                        gnt_idx  <= pick_idx;
                        rw_r     <= bus.req_rw[pick_idx];
                        stride_r <= bus.req_stride_en[pick_idx];
                        mask_r   <= bus.req_mask_en[pick_idx];
                        rx_r     <= bus.req_rx[pick_idx*FIELD_W +: FIELD_W];
                        ry_r     <= bus.req_ry[pick_idx*FIELD_W +: FIELD_W];
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_r  <= 1'b1;
                    wait_cnt <= 8'd0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completing MAU beats a simultaneous timeout.
                    if (bus.mau_done) begin
                        cmpl_r <= gnt_r;
                        state  <= ST_COMPLETE;
                    end else if (wait_cnt == TIMEOUT) begin
                        err_r  <= 1'b1;
                        cmpl_r <= gnt_r;
                        state  <= ST_COMPLETE;
                    end else if (!bus.halt_in) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_COMPLETE: begin
                    gnt_r    <= '0;
                    rr_ptr   <= next_ptr(gnt_idx);
                    wait_cnt <= 8'd0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = (state != ST_IDLE);
    assign bus.mau_halt      = bus.halt_in & bus.busy;
    assign bus.mau_start     = start_r;
    assign bus.mau_rw        = rw_r;
    assign bus.mau_stride_en = stride_r;
    assign bus.mau_mask_en   = mask_r;
    assign bus.mau_rx        = rx_r;
    assign bus.mau_ry        = ry_r;
    assign bus.gnt           = gnt_r;
    assign bus.cmpl          = cmpl_r;
    assign bus.err           = err_r;

endmodule

// File: tb/tb_mau_sched.sv
// Self-checking bench for mau_sched: directed scenarios plus randomized
// transfers scored against a round-robin reference model.
module tb_mau_sched;
    import mau_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mau_sched_if #(.NREQ(4)) bus();

    mau_sched #(.NREQ(4), .TIMEOUT(8'd200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;

    logic [3:0]   f_rw, f_str, f_msk;
    logic [127:0] f_rx, f_ry;

    typedef struct {
        logic [3:0]  g;
        logic        start;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rw;
        logic        st;
        logic        mk;
        logic [3:0]  cmpl;
        logic [3:0]  gnt_idle;
        logic        busy_idle;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: priority order is ptr, ptr+1, ... modulo 4.
    function automatic int model_pick(input logic [3:0] r, input int ptr);
        int order[$];
        for (int k = 0; k < 4; k++) order.push_back((ptr + k) % 4);
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic load_fields();
        f_rw  = 4'($urandom);
        f_str = 4'($urandom);
        f_msk = 4'($urandom);
        f_rx  = {$urandom, $urandom, $urandom, $urandom};
        f_ry  = {$urandom, $urandom, $urandom, $urandom};
        bus.req_rw = f_rw; bus.req_stride_en = f_str; bus.req_mask_en = f_msk;
        bus.req_rx = f_rx; bus.req_ry = f_ry;
    endtask

    task automatic scramble();
        bus.req = 4'($urandom);
        bus.req_rw = ~f_rw; bus.req_stride_en = ~f_str; bus.req_mask_en = ~f_msk;
        bus.req_rx = ~f_rx; bus.req_ry = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic restore();
        bus.req_rw = f_rw; bus.req_stride_en = f_str; bus.req_mask_en = f_msk;
        bus.req_rx = f_rx; bus.req_ry = f_ry;
    endtask

    // Drives one transfer starting from IDLE and records what was seen.
    task automatic run_xfer(input logic [3:0] reqv, input int done_after,
                            input bit scr, output obs_t o);
        bus.req = reqv;
        tick();
        o.g = bus.gnt;
        if (scr) scramble();
        tick();
        o.start = bus.mau_start; o.rx = bus.mau_rx; o.ry = bus.mau_ry;
        o.rw = bus.mau_rw; o.st = bus.mau_stride_en; o.mk = bus.mau_mask_en;
        repeat (done_after) tick();
        bus.mau_done = 1'b1;
        tick();
        bus.mau_done = 1'b0;
        o.cmpl = bus.cmpl;
        tick();
        o.gnt_idle = bus.gnt; o.busy_idle = bus.busy;
        if (scr) restore();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.halt_in = 1'b1; bus.mau_done = 1'b0;
        load_fields();
        do_reset();
        checks++; if (bus.gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.cmpl !== 4'b0) begin failures++; $display("FAIL reset_cmpl got=%b exp=0000", bus.cmpl); end
        checks++; if ({bus.busy, bus.err, bus.mau_start, bus.mau_halt} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got busy/err/start/halt=%b exp=0000", {bus.busy, bus.err, bus.mau_start, bus.mau_halt}); end
        checks++; if ({bus.mau_rx, bus.mau_ry, bus.mau_rw, bus.mau_stride_en, bus.mau_mask_en} !== 67'b0) begin failures++; $display("FAIL reset_cmd got rx=%h ry=%h exp=0", bus.mau_rx, bus.mau_ry); end
        bus.halt_in = 1'b0;
    endtask

    task automatic test_single();
        obs_t o;
        load_fields();
        f_rx[31:0] = 32'h10; f_ry[31:0] = 32'd2; f_str[0] = 1'b1;
        restore();
        run_xfer(4'b0001, 2, 1'b0, o);
        model_ptr = 1;
        checks++; if (o.g !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", o.g); end
        checks++; if (o.start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", o.start); end
        checks++; if (o.rx !== 32'h10 || o.ry !== 32'd2 || o.st !== 1'b1) begin failures++; $display("FAIL single_cmd got rx=%h ry=%h st=%b exp rx=10 ry=2 st=1", o.rx, o.ry, o.st); end
        checks++; if (o.cmpl !== 4'b0001) begin failures++; $display("FAIL single_cmpl got=%b exp=0001", o.cmpl); end
        checks++; if (o.gnt_idle !== 4'b0 || o.busy_idle !== 1'b0) begin failures++; $display("FAIL single_idle got gnt=%b busy=%b exp 0000/0", o.gnt_idle, o.busy_idle); end
    endtask

    task automatic test_all_four();
        obs_t o;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_xfer(4'b1111, 1, 1'b0, o);
            checks++; if (o.g !== (4'b0001 << k)) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, o.g, 4'b0001 << k); end
            checks++; if (o.cmpl !== (4'b0001 << k)) begin failures++; $display("FAIL rr_cmpl%0d got=%b exp=%b", k, o.cmpl, 4'b0001 << k); end
        end
        model_ptr = 0;
    endtask

    task automatic test_wrap();
        obs_t o;
        run_xfer(4'b0100, 0, 1'b0, o);
        checks++; if (o.g !== 4'b0100) begin failures++; $display("FAIL wrap_g2 got=%b exp=0100", o.g); end
        run_xfer(4'b1001, 0, 1'b0, o);
        checks++; if (o.g !== 4'b1000) begin failures++; $display("FAIL wrap_g3 got=%b exp=1000", o.g); end
        run_xfer(4'b1001, 0, 1'b0, o);
        checks++; if (o.g !== 4'b0001) begin failures++; $display("FAIL wrap_g0 got=%b exp=0001", o.g); end
        model_ptr = 1;
    endtask

    task automatic test_halt();
        int bad = 0;
        load_fields();
        bus.halt_in = 1'b1;
        #1;
        checks++; if (bus.mau_halt !== 1'b0) begin failures++; $display("FAIL halt_idle got=%b exp=0", bus.mau_halt); end
        bus.req = 4'b0010;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL halt_gnt got=%b exp=0010", bus.gnt); end
        tick();
        for (int i = 0; i < 50; i++) begin
            if (bus.mau_halt !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL halt_held got %0d low cycles exp 0", bad); end
        bus.halt_in = 1'b0;
        repeat (170) tick();
        checks++; if (bus.err !== 1'b0 || bus.cmpl !== 4'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL halt_frozen got err=%b cmpl=%b busy=%b exp 0/0000/1", bus.err, bus.cmpl, bus.busy); end
        bus.mau_done = 1'b1;
        tick();
        bus.mau_done = 1'b0;
        checks++; if (bus.cmpl !== 4'b0010 || bus.err !== 1'b0) begin failures++; $display("FAIL halt_cmpl got cmpl=%b err=%b exp 0010/0", bus.cmpl, bus.err); end
        tick();
        model_ptr = 2;
    endtask

    task automatic test_timeout();
        int n;
        obs_t o;
        bus.req = 4'b0001;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL to_gnt got=%b exp=0001", bus.gnt); end
        tick();
        repeat (150) tick();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL to_early_err got=%b exp=0", bus.err); end
        n = 150;
        while (bus.cmpl === 4'b0 && n < 400) begin
            tick();
            n++;
        end
        checks++; if (n < 199 || n > 202) begin failures++; $display("FAIL to_latency got=%0d cycles exp about 200", n); end
        checks++; if (bus.cmpl !== 4'b0001 || bus.err !== 1'b1) begin failures++; $display("FAIL to_cmpl got cmpl=%b err=%b exp 0001/1", bus.cmpl, bus.err); end
        tick();
        run_xfer(4'b0100, 3, 1'b0, o);
        checks++; if (o.g !== 4'b0100 || o.cmpl !== 4'b0100) begin failures++; $display("FAIL to_next got gnt=%b cmpl=%b exp 0100/0100", o.g, o.cmpl); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", bus.err); end
        model_ptr = 3;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        obs_t o;
        bus.req = 4'b1000;
        tick();
        checks++; if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL rm_gnt got=%b exp=1000", bus.gnt); end
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b0;
        checks++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL rm_state got gnt=%b busy=%b err=%b exp 0000/0/0", bus.gnt, bus.busy, bus.err); end
        for (int i = 0; i < 6; i++) begin
            if (bus.cmpl !== 4'b0) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rm_no_cmpl got %0d pulses exp 0", seen); end
        run_xfer(4'b1111, 0, 1'b0, o);
        checks++; if (o.g !== 4'b0001) begin failures++; $display("FAIL rm_ptr got=%b exp=0001", o.g); end
        model_ptr = 1;
    endtask

    task automatic test_random();
        obs_t o;
        logic [3:0] reqv;
        int idx;
        for (int it = 0; it < 24; it++) begin
            reqv = 4'($urandom_range(1, 15));
            load_fields();
            idx = model_pick(reqv, model_ptr);
            run_xfer(reqv, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), o);
            checks++; if (o.g !== (4'b0001 << idx)) begin failures++; $display("FAIL rand%0d_gnt req=%b got=%b exp=%b", it, reqv, o.g, 4'b0001 << idx); end
            checks++; if (o.start !== 1'b1) begin failures++; $display("FAIL rand%0d_start got=%b exp=1", it, o.start); end
            checks++; if (o.rx !== f_rx[32*idx +: 32] || o.ry !== f_ry[32*idx +: 32]) begin failures++; $display("FAIL rand%0d_addr got rx=%h ry=%h exp rx=%h ry=%h", it, o.rx, o.ry, f_rx[32*idx +: 32], f_ry[32*idx +: 32]); end
            checks++; if ({o.rw, o.st, o.mk} !== {f_rw[idx], f_str[idx], f_msk[idx]}) begin failures++; $display("FAIL rand%0d_ctl got=%b exp=%b", it, {o.rw, o.st, o.mk}, {f_rw[idx], f_str[idx], f_msk[idx]}); end
            checks++; if (o.cmpl !== (4'b0001 << idx)) begin failures++; $display("FAIL rand%0d_cmpl got=%b exp=%b", it, o.cmpl, 4'b0001 << idx); end
            model_ptr = (idx + 1) % 4;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_halt();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mau_sched.md
MAU_SCHED -- requirements
Module: mau_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the memory access unit; fixed at 4 for this revision.
REQ-002 SHALL have parameter TIMEOUT, default 8'd200, meaning the WAIT-state cycle limit before a timeout is flagged.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, synchronous and active-high.
REQ-005 SHALL have port req  input  4  meaning the per-requester access request, held high until cmpl.
REQ-006 SHALL have port req_rw  input  4  meaning the per-requester direction; 1 = store (vx to memory), 0 = load.
REQ-007 SHALL have port req_stride_en  input  4  meaning the per-requester stride enable.
REQ-008 SHALL have port req_mask_en  input  4  meaning the per-requester mask enable.
REQ-009 SHALL have port req_rx  input  128  meaning the per-requester base address, 32 bits each, requester i at [32i+31:32i].
REQ-010 SHALL have port req_ry  input  128  meaning the per-requester stride, 32 bits each, same packing as req_rx.
REQ-011 SHALL have port halt_in  input  1  meaning the pipeline stall request.
REQ-012 SHALL have port mau_done  input  1  meaning the MAU transfer-complete pulse.
REQ-013 SHALL have port mau_start, mau_rw, mau_stride_en, mau_mask_en, mau_halt  output  1 each  meaning the MAU command controls.
REQ-014 SHALL have port mau_rx, mau_ry  output  32 each  meaning the MAU base address and stride.
REQ-015 SHALL have port gnt  output  4  meaning the one-hot grant, held from select through COMPLETE.
REQ-016 SHALL have port cmpl  output  4  meaning the one-hot, one-cycle completion pulse to the granted requester.
REQ-017 SHALL have port busy  output  1  meaning the controller is not in IDLE.
REQ-018 SHALL have port err  output  1  meaning a sticky timeout flag.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT and COMPLETE.
REQ-020 SHALL, in IDLE with req!=0, grant the first set req bit searching from rr_ptr upward modulo 4, set the matching gnt bit, latch that requester's rw, stride_en, mask_en, rx and ry into the mau_* registers, and move to ISSUE.
REQ-021 SHALL, in ISSUE, drive mau_start=1 for exactly one cycle and then move to WAIT.
REQ-022 SHALL keep mau_start=0 in all other states, so the MAU never re-samples a second start.
REQ-023 SHALL hold the latched command registers constant from ISSUE through COMPLETE; requester bus changes in that window SHALL be ignored.
REQ-024 SHALL, in WAIT, increment an 8-bit wait counter each cycle halt_in=0; the counter SHALL be frozen while halt_in=1.
REQ-025 SHALL move from WAIT to COMPLETE on mau_done=1.
REQ-026 SHALL, in WAIT when the wait counter reaches TIMEOUT, set err=1 and move to COMPLETE.
REQ-027 SHALL give mau_done priority over the timeout when both occur in the same cycle, leaving err unchanged.
REQ-028 SHALL, in COMPLETE, pulse cmpl equal to gnt for one cycle, set rr_ptr to the granted index+1 modulo 4 (wrapping from 3 to 0), clear gnt, clear the wait counter, and return to IDLE.
REQ-029 SHALL not grant in the cycle it is in COMPLETE; the earliest next grant SHALL come one cycle after COMPLETE (IDLE).
REQ-030 SHALL give grant-to-mau_start latency of 1 cycle and mau_done-to-cmpl latency of 1 cycle.
REQ-031 SHALL ignore the granted requester dropping req mid-transfer; that transfer SHALL still complete and pulse cmpl.
REQ-032 SHALL drive mau_halt = halt_in & busy.
REQ-033 SHALL drive busy=1 whenever the state is not IDLE.

Reset
REQ-034 SHALL, on reset, force state=IDLE, rr_ptr=0, wait counter=0, gnt=0, cmpl=0, err=0, mau_start=0, all mau_* command outputs=0.
REQ-035 SHALL have reset mid-transfer abandon the transfer with no cmpl pulse.

Structure
REQ-036 SHALL place the FSM state encoding, NREQ and TIMEOUT defaults, and the 32-bit field width in a shared package.
REQ-037 SHALL use one sub-module, rr_arbiter4, as a combinational round-robin priority picker that takes req and rr_ptr and returns a one-hot grant plus an index.

Verification
REQ-038 SHALL cover: single request, req=0001, rx=0x10, ry=2, stride_en=1 -> gnt=0001; one cycle later mau_start=1 with mau_rx=0x10 and mau_ry=2; cmpl=0001 one cycle after mau_done.
REQ-039 SHALL cover: req=1111 held through four transfers from reset -> grants 0001, 0010, 0100, 1000 in that order.
REQ-040 SHALL cover: rr_ptr=3 after a requester-2 grant, req=1001 -> gnt=1000 first, then 0001.
REQ-041 SHALL cover: halt_in=1 for 50 cycles in WAIT with TIMEOUT=200 -> mau_halt=1 throughout, no err, and completion on mau_done.
REQ-042 SHALL cover: no mau_done -> err=1 at wait count 200 and a cmpl pulse; a following request still completes normally and err stays 1.
REQ-043 SHALL cover: reset asserted in WAIT -> next cycle IDLE, gnt=0, cmpl never pulsed, and rr_ptr=0.
